// File: rtl/frame_writer_pkg.sv
// rtl/frame_writer_pkg.sv - shared widths, screen defaults and FSM state type
package frame_writer_pkg;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 3;

  localparam int                 DEF_SCREEN_W = 160;
  localparam int                 DEF_SCREEN_H = 120;
  localparam logic [COLOR_W-1:0] DEF_BG_COLOR = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAW  = 2'd2
  } state_e;

endpackage

// File: rtl/frame_writer_clear_scanner.sv
// rtl/frame_writer_clear_scanner.sv - raster counter that sweeps every on-screen pixel
module clear_scanner
  import frame_writer_pkg::*;
#(
  parameter int W = DEF_SCREEN_W,
  parameter int H = DEF_SCREEN_H
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               advance,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               last
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(H - 1);

  logic [COORD_W-1:0] cx_q, cx_d;
  logic [COORD_W-1:0] cy_q, cy_d;

  assign last = (cx_q == X_MAX) && (cy_q == Y_MAX);
  assign cx   = cx_q;
  assign cy   = cy_q;

  // Next raster position: x wraps into y, and the final pixel wraps both back to origin.
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (start) begin
      cx_d = '0;
      cy_d = '0;
    end else if (advance) begin
      if (cx_q == X_MAX) begin
        cx_d = '0;
        cy_d = last ? '0 : cy_q + COORD_W'(1);
      end else begin
        cx_d = cx_q + COORD_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - clears the screen then forwards clipped draw pixels to the VGA write port
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int                 SCREEN_W = DEF_SCREEN_W,
  parameter int                 SCREEN_H = DEF_SCREEN_H,
  parameter logic [COLOR_W-1:0] BG_COLOR = DEF_BG_COLOR
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               in_plot,
  input  logic               draw_frame_done,
  output logic               draw_enable,
  output logic [COORD_W-1:0] vga_x,
  output logic [COORD_W-1:0] vga_y,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_plot,
  output logic               frame_done,
  output logic [15:0]        clip_count
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H);

  state_e state_q, state_d;

  logic [COORD_W-1:0] vga_x_q, vga_x_d;
  logic [COORD_W-1:0] vga_y_q, vga_y_d;
  logic [COLOR_W-1:0] vga_color_q, vga_color_d;
  logic               vga_plot_q, vga_plot_d;
  logic               draw_enable_q, draw_enable_d;
  logic               frame_done_q, frame_done_d;
  logic [15:0]        clip_q, clip_d;

  logic [COORD_W-1:0] cx, cy;
  logic               scan_last;
  logic               scan_start;
  logic               scan_advance;
  logic               on_screen;

  assign scan_start   = (state_q == ST_IDLE) && frame_start;
  assign scan_advance = (state_q == ST_CLEAR);
  assign on_screen    = (in_x < X_LIM) && (in_y < Y_LIM);

  clear_scanner #(
    .W (SCREEN_W),
    .H (SCREEN_H)
  ) u_scanner (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (scan_start),
    .advance (scan_advance),
    .cx      (cx),
    .cy      (cy),
    .last    (scan_last)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_color_d  = vga_color_q;
    vga_plot_d   = 1'b0;
    frame_done_d = 1'b0;
    clip_d       = clip_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_CLEAR;
          clip_d  = '0;
        end
      end
      ST_CLEAR: begin
        vga_x_d     = cx;
        vga_y_d     = cy;
        vga_color_d = BG_COLOR;
        vga_plot_d  = 1'b1;
        if (scan_last) begin
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        vga_x_d     = in_x;
        vga_y_d     = in_y;
        vga_color_d = in_color;
        vga_plot_d  = in_plot && on_screen;
        if (in_plot && !on_screen && (clip_q != 16'hFFFF)) begin
          clip_d = clip_q + 16'd1;
        end
        // A pixel arriving with the done flag is still handled above.
        if (draw_frame_done) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    draw_enable_d = (state_d == ST_DRAW);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output and clip-counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      vga_color_q   <= '0;
      vga_plot_q    <= 1'b0;
      draw_enable_q <= 1'b0;
      frame_done_q  <= 1'b0;
      clip_q        <= '0;
    end else begin
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      vga_color_q   <= vga_color_d;
      vga_plot_q    <= vga_plot_d;
      draw_enable_q <= draw_enable_d;
      frame_done_q  <= frame_done_d;
      clip_q        <= clip_d;
    end
  end

  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_color   = vga_color_q;
  assign vga_plot    = vga_plot_q;
  assign draw_enable = draw_enable_q;
  assign frame_done  = frame_done_q;
  assign clip_count  = clip_q;

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - scoreboard bench for frame_writer
module tb_frame_writer;

  localparam int W = 160;
  localparam int H = 120;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic [9:0]  in_x;
  logic [9:0]  in_y;
  logic [2:0]  in_color;
  logic        in_plot;
  logic        draw_frame_done;
  logic        draw_enable;
  logic [9:0]  vga_x;
  logic [9:0]  vga_y;
  logic [2:0]  vga_color;
  logic        vga_plot;
  logic        frame_done;
  logic [15:0] clip_count;

  int checks   = 0;
  int failures = 0;

  logic [22:0] exp_q[$];
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  frame_writer #(
    .SCREEN_W (W),
    .SCREEN_H (H),
    .BG_COLOR (3'b000)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .frame_start     (frame_start),
    .in_x            (in_x),
    .in_y            (in_y),
    .in_color        (in_color),
    .in_plot         (in_plot),
    .draw_frame_done (draw_frame_done),
    .draw_enable     (draw_enable),
    .vga_x           (vga_x),
    .vga_y           (vga_y),
    .vga_color       (vga_color),
    .vga_plot        (vga_plot),
    .frame_done      (frame_done),
    .clip_count      (clip_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Every plotted pixel must match the oldest expected pixel; all-ones marks "nothing expected".
  always @(negedge clk) begin
    if (mon_en && vga_plot === 1'b1) begin
      logic [22:0] e;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = '1;
      check_eq("pix", {9'd0, vga_x, vga_y, vga_color}, {9'd0, e});
    end
  end

  task automatic push_clear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({10'(x), 10'(y), 3'b000});
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic drive_px(input int x, input int y, input logic [2:0] c,
                          input logic plot, input logic done);
    in_x            = 10'(x);
    in_y            = 10'(y);
    in_color        = c;
    in_plot         = plot;
    draw_frame_done = done;
    if (plot && x < W && y < H) exp_q.push_back({10'(x), 10'(y), c});
    @(posedge clk);
    #1;
    in_plot         = 1'b0;
    draw_frame_done = 1'b0;
  endtask

  task automatic run_clear(input string tag, input bit poke);
    int plots = 0;
    bit seen  = 1'b0;
    for (int i = 0; i < 25000; i++) begin
      @(negedge clk);
      if (poke && i == 100) frame_start = 1'b1;
      if (poke && i == 101) frame_start = 1'b0;
      if (vga_plot) plots++;
      if (draw_enable) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    check_eq({tag, "_draw_enable_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_clear_plots"}, plots, W * H);
    check_eq({tag, "_last_clear_px"}, {vga_x, vga_y, vga_color, vga_plot},
             {10'd159, 10'd119, 3'd0, 1'b1});
    check_eq({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    bit found;
    reset_n         = 1'b0;
    frame_start     = 1'b0;
    in_x            = '0;
    in_y            = '0;
    in_color        = '0;
    in_plot         = 1'b0;
    draw_frame_done = 1'b0;
    #23;
    check_eq("reset_outs", {vga_x, vga_y, vga_color, vga_plot, draw_enable, frame_done}, 32'd0);
    check_eq("reset_clip", clip_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_no_plot", {vga_plot, draw_enable}, 32'd0);

    // Frame 1: full clear with a stray frame_start mid-sweep, then draw traffic.
    push_clear();
    pulse_start();
    run_clear("f1", 1'b1);

    drive_px(5, 7, 3'b101, 1'b1, 1'b0);
    check_eq("draw_latency", {vga_x, vga_y, vga_color, vga_plot}, {10'd5, 10'd7, 3'd5, 1'b1});
    drive_px(160, 10, 3'b001, 1'b1, 1'b0);
    check_eq("clip_x_plot", vga_plot, 32'd0);
    drive_px(3, 120, 3'b010, 1'b1, 1'b0);
    check_eq("clip_y_plot", vga_plot, 32'd0);
    drive_px(1023, 1023, 3'b011, 1'b1, 1'b0);
    check_eq("clip_max_plot", vga_plot, 32'd0);
    check_eq("clip_count_3", clip_count, 32'd3);
    drive_px(159, 119, 3'b110, 1'b1, 1'b0);
    check_eq("edge_px_plot", {vga_plot, clip_count}, {1'b1, 16'd3});
    drive_px(0, 0, 3'b111, 1'b0, 1'b0);
    check_eq("no_plot_no_clip", {vga_plot, clip_count}, {1'b0, 16'd3});
    drive_px(2, 2, 3'b011, 1'b1, 1'b1);
    check_eq("done_px", {vga_x, vga_y, vga_color, vga_plot}, {10'd2, 10'd2, 3'd3, 1'b1});
    check_eq("done_pulse", {frame_done, draw_enable}, {1'b1, 1'b0});

    // Frame 2 requested on the earliest accepted edge; reset hits mid-clear.
    push_clear();
    pulse_start();
    check_eq("f2_start", {frame_done, draw_enable, vga_plot, clip_count}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (vga_plot && vga_x == 10'd39 && vga_y == 10'd3) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("f2_reached_40_3", 32'(found), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_reset_outs",
             {vga_x, vga_y, vga_color, vga_plot, draw_enable, frame_done}, 32'd0);
    check_eq("async_reset_clip", clip_count, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("post_reset_idle", {vga_plot, draw_enable, frame_done}, 32'd0);

    // Frame 3: clear must restart from the origin.
    push_clear();
    pulse_start();
    run_clear("f3", 1'b0);
    drive_px(0, 0, 3'b000, 1'b0, 1'b1);
    check_eq("f3_done", {frame_done, draw_enable, clip_count}, {1'b1, 1'b0, 16'd0});
    @(posedge clk);
    #1;
    check_eq("f3_done_clears", {frame_done, vga_plot}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
# frame_writer

Pixel-stream stage between the draw controller and the VGA adapter's write port. Each frame it first clears the screen by sweeping every on-screen pixel with the background colour. It then passes the draw controller's pixel stream through, registered, and drops off-screen pixels. It sequences frames with a start/done handshake and counts clipped pixels for debug.

## Interface
Parameters:
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- BG_COLOR, 3'b000, clear colour

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle request to begin a frame; honoured only in IDLE
- in_x  in  10  pixel x from draw controller
- in_y  in  10  pixel y from draw controller
- in_color  in  3  pixel colour from draw controller
- in_plot  in  1  pixel valid from draw controller
- draw_frame_done  in  1  upstream has emitted its last pixel of the frame
- draw_enable  out  1  upstream may emit pixels; high exactly while in DRAW
- vga_x  out  10  pixel x to VGA adapter
- vga_y  out  10  pixel y to VGA adapter
- vga_color  out  3  pixel colour to VGA adapter
- vga_plot  out  1  write enable to VGA adapter
- frame_done  out  1  one-cycle pulse when the frame finishes
- clip_count  out  16  off-screen pixels dropped in current frame

## Operation
- States: IDLE, CLEAR, DRAW.
- IDLE:
  - vga_plot=0.
  - frame_start → CLEAR; clear counters cx=cy=0; clip_count←0.
- CLEAR:
  - Each cycle registers vga_x=cx, vga_y=cy, vga_color=BG_COLOR, vga_plot=1.
  - cx increments and wraps at SCREEN_W-1 to 0, incrementing cy.
  - Pixel (SCREEN_W-1, SCREEN_H-1) is the last one. On that cycle the state moves to DRAW and the counters return to 0.
  - in_* and draw_frame_done are ignored.
- DRAW:
  - Each cycle registers vga_x/y/color from in_x/in_y/in_color.
  - vga_plot = in_plot && in_x<SCREEN_W && in_y<SCREEN_H. Comparisons are unsigned, full 10 bits.
  - in_plot with an off-screen coordinate: vga_plot=0; clip_count increments, saturating at 16'hFFFF.
  - draw_frame_done → IDLE and frame_done pulses. A pixel presented in the same cycle is still written or clipped normally.
- frame_start outside IDLE is ignored. It is not queued.
- Reset, asynchronous and at any time including mid-CLEAR or mid-DRAW:
  - state=IDLE, cx=cy=0.
  - vga_x=vga_y=0, vga_color=0, vga_plot=0.
  - draw_enable=0, frame_done=0, clip_count=0.

## Timing
- All outputs are registered; none are combinational from inputs.
- Edge E0 samples frame_start in IDLE.
- Edge E1 presents clear pixel (0,0).
- Edge E(W·H) presents (W-1,H-1) and sets draw_enable=1 (19200 clear cycles at defaults).
- DRAW latency: in_* sampled at edge En appears on vga_* after En (1 cycle).
- draw_frame_done sampled at edge En: at En, draw_enable←0 and frame_done←1; at En+1, frame_done←0.
- IDLE→CLEAR requires a sampled frame_start. The earliest next frame_start is accepted one edge after frame_done rises.
- Throughput: one pixel per cycle in both CLEAR and DRAW; no backpressure.

## Structure
- frame_writer_pkg holds:
  - the state enum (IDLE, CLEAR, DRAW);
  - the default SCREEN_W/SCREEN_H/BG_COLOR constants;
  - the shared colour width (3) and coordinate width (10).
- Sub-module clear_scanner holds the cx/cy raster counter.
  - Ports: clk, reset_n, start, advance, cx, cy, last.
  - last is asserted at (W-1, H-1).
- The top level holds the FSM, the output registers, the clip logic and the saturating counter.

## Test plan
- Reset then frame_start pulse: exactly 19200 consecutive vga_plot=1 cycles with vga_color=0, covering (0,0)…(159,0),(0,1)…(159,119); then draw_enable=1.
- DRAW with in_x=5, in_y=7, in_color=3'b101, in_plot=1: one edge later vga_x=5, vga_y=7, vga_color=5, vga_plot=1.
- DRAW with in_plot=1 at (160,10), then (3,120), then (1023,1023): vga_plot stays 0 and clip_count=3. On the next frame_start, clip_count returns to 0.
- draw_frame_done together with in_plot=1 at (2,2): pixel written; frame_done high one cycle; state IDLE; draw_enable=0. A frame_start pulsed during CLEAR is ignored.
- reset_n driven low mid-CLEAR at cx=40, cy=3: all outputs are 0 immediately (asynchronous). After release, no plotting until frame_start; the next clear starts at (0,0).
